// File: rtl/tx_link_ctrl_8b10b.sv
// Transmit link controller in front of an 8b/10b encoder: comma training,
// SOF/EOF framing with fill insertion, and the running-disparity register.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_OFF   | link disabled, 0x00/D sent
// ST_TRAIN | alternating K28.5 / D10.2 training run of TRAIN_LEN symbols
// ST_IDLE  | link up, K28.5 idles until a frame is offered
// ST_DATA  | payload bytes accepted, K28.0 fill when the source stalls
// ST_EOF   | K29.7 delimiter being loaded, frame counted
// ST_GAP   | IFG K28.5 idles enforced after every EOF
module tx_link_ctrl_8b10b #(
    parameter int TRAIN_LEN = 16,
    parameter int IFG       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  enc_data,
    output logic        enc_k,
    output logic        enc_dispin,
    input  logic        enc_dispout,
    output logic        link_up,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] SYM_COMMA   = 8'hBC;
    localparam logic [7:0] SYM_TRAIN_D = 8'h4A;
    localparam logic [7:0] SYM_SOF     = 8'hFB;
    localparam logic [7:0] SYM_EOF     = 8'hFD;
    localparam logic [7:0] SYM_FILL    = 8'h1C;
    localparam logic [7:0] SYM_OFF     = 8'h00;

    localparam int CNT_MAX = (TRAIN_LEN > IFG) ? TRAIN_LEN : IFG;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_TRAIN = 3'd1,
        ST_IDLE  = 3'd2,
        ST_DATA  = 3'd3,
        ST_EOF   = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    assign s_ready = (state == ST_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            cnt        <= '0;
            enc_data   <= SYM_OFF;
            enc_k      <= 1'b0;
            enc_dispin <= 1'b0;
            link_up    <= 1'b0;
            underrun   <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            enc_dispin <= enc_dispout;
            underrun   <= 1'b0;
            case (state)
                ST_OFF: begin
                    enc_data <= SYM_OFF;
                    enc_k    <= 1'b0;
                    if (enable) begin
                        state <= ST_TRAIN;
                        cnt   <= CW'(TRAIN_LEN - 1);
                    end
                end
                ST_TRAIN: begin
                    if (!enable) begin
                        enc_data <= SYM_OFF;
                        enc_k    <= 1'b0;
                        state    <= ST_OFF;
                        cnt      <= '0;
                    end else begin
                        // cnt counts down from TRAIN_LEN-1 (even length), so an
                        // odd remainder marks an even symbol index -> comma.
                        if (cnt[0]) begin
                            enc_data <= SYM_COMMA;
                            enc_k    <= 1'b1;
                        end else begin
                            enc_data <= SYM_TRAIN_D;
                            enc_k    <= 1'b0;
                        end
                        if (cnt == '0) begin
                            state   <= ST_IDLE;
                            link_up <= 1'b1;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (!enable) begin
                        enc_data <= SYM_OFF;
                        enc_k    <= 1'b0;
                        state    <= ST_OFF;
                        link_up  <= 1'b0;
                    end else if (s_valid) begin
                        enc_data <= SYM_SOF;
                        enc_k    <= 1'b1;
                        state    <= ST_DATA;
                    end else begin
                        enc_data <= SYM_COMMA;
                        enc_k    <= 1'b1;
                    end
                end
                ST_DATA: begin
                    // enable is deliberately ignored so a started frame always closes
                    if (s_valid) begin
                        enc_data <= s_data;
                        enc_k    <= 1'b0;
                        if (s_last) begin
                            state <= ST_EOF;
                        end
                    end else begin
                        enc_data <= SYM_FILL;
                        enc_k    <= 1'b1;
                        underrun <= 1'b1;
                    end
                end
                ST_EOF: begin
                    enc_data  <= SYM_EOF;
                    enc_k     <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= ST_GAP;
                    cnt       <= CW'(IFG - 1);
                end
                ST_GAP: begin
                    enc_data <= SYM_COMMA;
                    enc_k    <= 1'b1;
                    if (cnt == '0) begin
                        if (enable) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_OFF;
                            link_up <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    enc_data <= SYM_OFF;
                    enc_k    <= 1'b0;
                    state    <= ST_OFF;
                    cnt      <= '0;
                    link_up  <= 1'b0;
                end
            endcase
        end
    end

endmodule
